// File: rtl/uart_fifo_pkg.sv
// Shared types and helpers for the UART TX FIFO pop path.
package uart_fifo_pkg;

  typedef enum logic {IDLE, DRAIN} pop_seq_state_t;

  function automatic int unsigned min_cnt(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/mpmp_fifo_pop_sequencer.sv
// Pops up to MAXB FIFO words in one cycle and serialises them one word per tx handshake.
// First word appears the cycle after pop; 1 word/cycle across bursts; tx_ready low holds word, index and state.
module mpmp_fifo_pop_sequencer
  import uart_fifo_pkg::*;
#(
  parameter int W    = 8,
  parameter int NO   = 4,
  parameter int MAXB = NO,
  parameter int WN   = $clog2(NO + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [WN-1:0]   can_pop,
  input  logic [NO*W-1:0] pop_data,
  output logic [WN-1:0]   pop,
  output logic [W-1:0]    tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy
);

  pop_seq_state_t state_q, state_d;
  logic [W-1:0]   buf_q [MAXB];
  logic [W-1:0]   buf_d [MAXB];
  logic [WN-1:0]  cnt_q, cnt_d;
  logic [WN-1:0]  idx_q, idx_d;
  logic [WN-1:0]  take;
  logic           hs;
  logic           last_hs;
  logic           load;

  always_comb begin
    take     = WN'(min_cnt(32'(can_pop), MAXB));
    tx_valid = (state_q == DRAIN);
    busy     = tx_valid;
    hs       = tx_valid && tx_ready;
    last_hs  = hs && (idx_q == cnt_q - WN'(1));
    // A new burst may start only from IDLE or on the final word's handshake, so bursts never overlap.
    load     = enable && (take != '0) && ((state_q == IDLE) || last_hs);
    pop      = (load && !rst) ? take : '0;
    tx_data  = '0;
    for (int i = 0; i < MAXB; i++) begin
      if (tx_valid && (idx_q == WN'(i))) tx_data = buf_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (load) begin
      for (int i = 0; i < MAXB; i++) begin
        if (WN'(i) < take) buf_d[i] = pop_data[i*W +: W];
      end
      cnt_d   = take;
      idx_d   = '0;
      state_d = DRAIN;
    end else if (last_hs) begin
      state_d = IDLE;
    end else if (hs) begin
      idx_d = idx_q + WN'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      buf_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_mpmp_fifo_pop_sequencer.sv
// Directed bench: behavioural FIFO models feed a full-burst and a MAXB=2 sequencer.
module tb_mpmp_fifo_pop_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0, en1, rdy0, rdy1;
  logic [2:0]  can_pop0, can_pop1, pop0, pop1;
  logic [31:0] pop_data0, pop_data1;
  logic [7:0]  txd0, txd1;
  logic        txv0, txv1, busy0, busy1;

  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  mpmp_fifo_pop_sequencer #(.W(8), .NO(4), .MAXB(4)) u_dut0 (
    .clk(clk), .rst(rst), .enable(en0), .can_pop(can_pop0), .pop_data(pop_data0),
    .pop(pop0), .tx_data(txd0), .tx_valid(txv0), .tx_ready(rdy0), .busy(busy0)
  );

  mpmp_fifo_pop_sequencer #(.W(8), .NO(4), .MAXB(2)) u_dut1 (
    .clk(clk), .rst(rst), .enable(en1), .can_pop(can_pop1), .pop_data(pop_data1),
    .pop(pop1), .tx_data(txd1), .tx_valid(txv1), .tx_ready(rdy1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ports();
    can_pop0 = 3'((q0.size() > 4) ? 4 : q0.size());
    can_pop1 = 3'((q1.size() > 4) ? 4 : q1.size());
    for (int i = 0; i < 4; i++) begin
      pop_data0[i*8 +: 8] = (i < q0.size()) ? q0[i] : 8'h00;
      pop_data1[i*8 +: 8] = (i < q1.size()) ? q1[i] : 8'h00;
    end
  endtask

  // One clock: sample pop just before the edge, retire popped words, then settle.
  task automatic cyc();
    int p0, p1;
    set_ports();
    #1;
    p0 = int'(pop0);
    p1 = int'(pop1);
    @(posedge clk);
    #1;
    repeat (p0) void'(q0.pop_front());
    repeat (p1) void'(q1.pop_front());
    set_ports();
    #1;
  endtask

  initial begin
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
    set_ports();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_txv", 32'(txv0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_txd", 32'(txd0), 0);
    chk("rst_pop", 32'(pop0), 0);

    // 1: three-word burst
    q0.push_back(8'd1); q0.push_back(8'd2); q0.push_back(8'd3);
    en0 = 1'b1; rdy0 = 1'b1;
    set_ports(); #1;
    chk("rst_blocks_pop", 32'(pop0), 0);
    rst = 1'b0; #1;
    chk("t1_pop", 32'(pop0), 3);
    cyc();
    chk("t1_w1", 32'(txd0), 1);
    chk("t1_txv", 32'(txv0), 1);
    chk("t1_busy", 32'(busy0), 1);
    chk("t1_pop_idle", 32'(pop0), 0);
    cyc(); chk("t1_w2", 32'(txd0), 2);
    cyc(); chk("t1_w3", 32'(txd0), 3);
    cyc();
    chk("t1_end_txv", 32'(txv0), 0);
    chk("t1_end_busy", 32'(busy0), 0);
    chk("t1_end_pop", 32'(pop0), 0);

    // 2: backpressure holds the head word
    for (int i = 5; i <= 8; i++) q0.push_back(8'(i));
    set_ports(); #1;
    chk("t2_pop", 32'(pop0), 4);
    cyc(); chk("t2_w5", 32'(txd0), 5);
    rdy0 = 1'b0;
    cyc(); chk("t2_stall1", 32'(txd0), 5); chk("t2_stall_txv", 32'(txv0), 1);
    cyc(); chk("t2_stall2", 32'(txd0), 5); chk("t2_stall_pop", 32'(pop0), 0);
    rdy0 = 1'b1;
    cyc(); chk("t2_w6", 32'(txd0), 6);
    cyc(); chk("t2_w7", 32'(txd0), 7);
    cyc(); chk("t2_w8", 32'(txd0), 8); chk("t2_busy8", 32'(busy0), 1);
    cyc(); chk("t2_busy_end", 32'(busy0), 0);

    // 3: back-to-back bursts with no bubble
    for (int i = 1; i <= 8; i++) q0.push_back(8'(i));
    set_ports(); #1;
    chk("t3_pop_a", 32'(pop0), 4);
    cyc(); chk("t3_w1", 32'(txd0), 1); chk("t3_pop_mid", 32'(pop0), 0);
    cyc(); chk("t3_w2", 32'(txd0), 2);
    cyc(); chk("t3_w3", 32'(txd0), 3);
    cyc(); chk("t3_w4", 32'(txd0), 4); chk("t3_pop_b", 32'(pop0), 4);
    cyc(); chk("t3_w5", 32'(txd0), 5); chk("t3_txv5", 32'(txv0), 1);
    cyc(); chk("t3_w6", 32'(txd0), 6);
    cyc(); chk("t3_w7", 32'(txd0), 7);
    cyc(); chk("t3_w8", 32'(txd0), 8); chk("t3_pop_empty", 32'(pop0), 0);
    cyc(); chk("t3_end_txv", 32'(txv0), 0);

    // 4: burst cap of two
    for (int i = 9; i <= 12; i++) q1.push_back(8'(i));
    en1 = 1'b1; rdy1 = 1'b1;
    set_ports(); #1;
    chk("t4_pop_a", 32'(pop1), 2);
    cyc(); chk("t4_w9", 32'(txd1), 9); chk("t4_pop_mid", 32'(pop1), 0);
    cyc(); chk("t4_w10", 32'(txd1), 10); chk("t4_pop_b", 32'(pop1), 2);
    cyc(); chk("t4_w11", 32'(txd1), 11);
    cyc(); chk("t4_w12", 32'(txd1), 12); chk("t4_pop_empty", 32'(pop1), 0);
    cyc(); chk("t4_end_txv", 32'(txv1), 0);
    en1 = 1'b0;

    // 5: enable dropped mid-burst finishes the burst only
    for (int i = 1; i <= 8; i++) q0.push_back(8'(i));
    set_ports(); #1;
    chk("t5_pop", 32'(pop0), 4);
    cyc(); chk("t5_w1", 32'(txd0), 1);
    en0 = 1'b0;
    cyc(); chk("t5_w2", 32'(txd0), 2);
    cyc(); chk("t5_w3", 32'(txd0), 3);
    cyc(); chk("t5_w4", 32'(txd0), 4); chk("t5_no_pop_last", 32'(pop0), 0);
    cyc(); chk("t5_idle_txv", 32'(txv0), 0); chk("t5_idle_pop", 32'(pop0), 0);
    chk("t5_fifo_left", q0.size(), 4);
    cyc(); chk("t5_still_idle", 32'(busy0), 0);

    // 6: reset mid-burst discards buffered words
    q0.push_back(8'd9); q0.push_back(8'd10);
    en0 = 1'b1;
    set_ports(); #1;
    chk("t6_pop", 32'(pop0), 4);
    cyc(); chk("t6_w5", 32'(txd0), 5);
    cyc(); chk("t6_w6", 32'(txd0), 6);
    cyc(); chk("t6_w7", 32'(txd0), 7);
    rst = 1'b1; #1;
    chk("t6_rst_txv", 32'(txv0), 0);
    chk("t6_rst_busy", 32'(busy0), 0);
    chk("t6_rst_pop", 32'(pop0), 0);
    chk("t6_rst_txd", 32'(txd0), 0);
    cyc();
    chk("t6_fifo_kept", q0.size(), 2);
    rst = 1'b0;
    set_ports(); #1;
    chk("t6_pop_rest", 32'(pop0), 2);
    cyc(); chk("t6_w9", 32'(txd0), 9);
    cyc(); chk("t6_w10", 32'(txd0), 10);
    cyc(); chk("t6_end_txv", 32'(txv0), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
